// File: rtl/ghostbus_byte_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ghostbus_byte_host_pkg
// Description : Shared definitions for the ghostbus byte-stream host bridge.
//               Holds the command byte codes, the FSM state encoding and the
//               byte-count helper used to size the address/data fields.
// Contents    : CMD_WR, CMD_RD, ST_* state codes, state_t, nbytes()
// Revision    : 1.0 - initial release
// ============================================================================
package ghostbus_byte_host_pkg;

  // Command bytes recognised in IDLE.
  localparam logic [7:0] CMD_WR = 8'h80;
  localparam logic [7:0] CMD_RD = 8'h00;

  // State encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_WSTB  = 3'd3;
  localparam logic [2:0] ST_RSTB  = 3'd4;
  localparam logic [2:0] ST_RWAIT = 3'd5;
  localparam logic [2:0] ST_RSEND = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ADDR  = ST_ADDR,
    WDATA = ST_WDATA,
    WSTB  = ST_WSTB,
    RSTB  = ST_RSTB,
    RWAIT = ST_RWAIT,
    RSEND = ST_RSEND
  } state_t;

  // Number of bytes needed to carry a W-bit field (W is a multiple of 8).
  function automatic int nbytes(input int w);
    return w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ghostbus_byte_host_if.sv
`default_nettype none
// ============================================================================
// Module      : ghostbus_byte_host_if
// Description : Bundles the inbound byte stream, outbound byte stream and the
//               single-beat ghostbus signals of the byte host bridge.
// Ports       : in_data/in_valid/in_ready   - command byte stream (to host)
//               out_data/out_valid/out_ready - read-data byte stream (from host)
//               gb_addr/gb_wdata/gb_we/gb_re/gb_rdata - ghostbus
// Modports    : master - the bridge side; slave - the environment side
// Revision    : 1.0 - initial release
// ============================================================================
interface ghostbus_byte_host_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_we;
  logic          gb_re;
  logic [DW-1:0] gb_rdata;

  modport master (
    input  in_data, in_valid, out_ready, gb_rdata,
    output in_ready, out_data, out_valid, gb_addr, gb_wdata, gb_we, gb_re
  );

  modport slave (
    output in_data, in_valid, out_ready, gb_rdata,
    input  in_ready, out_data, out_valid, gb_addr, gb_wdata, gb_we, gb_re
  );
endinterface
`default_nettype wire

// File: rtl/ghostbus_byte_host_ser.sv
`default_nettype none
// ============================================================================
// Module      : gb_byte_ser
// Description : DW-bit to byte-stream serializer, MSB byte first. A load
//               captures a word and raises out_valid; each out_valid&out_ready
//               handshake shifts one byte out. done pulses combinationally in
//               the cycle of the final handshake, and out_valid drops on that
//               same edge.
// Ports       : clk, rst (async, active high)
//               load, load_data     - capture a new word
//               out_data, out_valid, out_ready - byte stream
//               done                - final-byte handshake in this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module gb_byte_ser
  import ghostbus_byte_host_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  output logic          done
);

  localparam int NB = nbytes(DW);
  localparam int CW = $clog2(NB + 1);

  logic [DW-1:0] r_sh;
  logic [CW-1:0] r_left;
  logic          r_valid;
  logic          w_hs;
  logic          w_last;

  assign w_hs      = r_valid & out_ready;
  assign w_last    = (r_left == CW'(1));
  assign done      = w_hs & w_last;
  assign out_valid = r_valid;
  assign out_data  = r_sh[DW-1 -: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh    <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_sh    <= load_data;
      r_left  <= CW'(NB);
      r_valid <= 1'b1;
    end else if (w_hs) begin
      r_sh   <= r_sh << 8;
      r_left <= r_left - CW'(1);
      if (w_last) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ghostbus_byte_host.sv
`default_nettype none
// ============================================================================
// Module      : ghostbus_byte_host
// Description : Host-side ghostbus master. Parses a byte stream of
//               [cmd][addr MSB..LSB]([data MSB..LSB]) packets into single-beat
//               ghostbus writes (cmd 0x80) and reads (cmd 0x00); read data is
//               returned MSB byte first on the outbound stream. Unknown
//               command bytes are dropped and counted (saturating).
// Ports       : clk, rst (async assert, active high)
//               bus     - ghostbus_byte_host_if.master (streams + ghostbus)
//               busy    - high whenever the FSM is not IDLE
//               err_cnt - rejected command bytes, saturates at 255
// Revision    : 1.0 - initial release
// ============================================================================
module ghostbus_byte_host
  import ghostbus_byte_host_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ghostbus_byte_host_if.master bus,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  localparam int NA   = nbytes(AW);
  localparam int NW   = nbytes(DW);
  localparam int NMAX = (NA > NW) ? NA : NW;
  localparam int BCW  = $clog2(NMAX + 1);

  state_t         r_state;
  state_t         w_next;

  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [BCW-1:0] r_bcnt;
  logic           r_is_wr;
  logic [3:0]     r_lat;
  logic [7:0]     r_err;

  logic           w_in_ready;
  logic           w_we;
  logic           w_re;
  logic           w_busy;
  logic           w_accept;
  logic           w_cmd_ok;
  logic           w_addr_last;
  logic           w_data_last;
  logic           w_ser_load;
  logic           w_ser_done;

  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_cmd_ok    = (bus.in_data == CMD_WR) || (bus.in_data == CMD_RD);
  assign w_addr_last = (r_bcnt == BCW'(NA - 1));
  assign w_data_last = (r_bcnt == BCW'(NW - 1));
  // The read latency counter reaches zero in cycle T+RD_LAT, which is the
  // cycle whose closing edge must capture gb_rdata.
  assign w_ser_load  = (r_state == RWAIT) && (r_lat == 4'd0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs. Strobes decode straight from the
  // state register so an asynchronous reset kills them immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (w_accept && w_cmd_ok) begin
          w_next = ADDR;
        end
      end
      ADDR: begin
        w_in_ready = 1'b1;
        if (w_accept && w_addr_last) begin
          w_next = r_is_wr ? WDATA : RSTB;
        end
      end
      WDATA: begin
        w_in_ready = 1'b1;
        if (w_accept && w_data_last) begin
          w_next = WSTB;
        end
      end
      WSTB: begin
        w_we   = 1'b1;
        w_next = IDLE;
      end
      RSTB: begin
        w_re   = 1'b1;
        w_next = RWAIT;
      end
      RWAIT: begin
        if (r_lat == 4'd0) begin
          w_next = RSEND;
        end
      end
      RSEND: begin
        if (w_ser_done) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address/data deserializers, byte counter, latency counter and
  // the rejected-command counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_bcnt  <= '0;
      r_is_wr <= 1'b0;
      r_lat   <= 4'd0;
      r_err   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_bcnt <= '0;
            if (w_cmd_ok) begin
              r_is_wr <= (bus.in_data == CMD_WR);
            end else if (r_err != 8'hFF) begin
              r_err <= r_err + 8'd1;
            end
          end
        end
        ADDR: begin
          if (w_accept) begin
            // AW/8 shifts fully overwrite the previous address.
            r_addr <= (r_addr << 8) | AW'(bus.in_data);
            r_bcnt <= w_addr_last ? '0 : r_bcnt + BCW'(1);
          end
        end
        WDATA: begin
          if (w_accept) begin
            r_wdata <= (r_wdata << 8) | DW'(bus.in_data);
            r_bcnt  <= w_data_last ? '0 : r_bcnt + BCW'(1);
          end
        end
        RSTB: begin
          r_lat <= 4'(RD_LAT - 1);
        end
        RWAIT: begin
          if (r_lat != 4'd0) begin
            r_lat <= r_lat - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read-data return path
  // --------------------------------------------------------------------------
  gb_byte_ser #(
    .DW (DW)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (w_ser_load),
    .load_data (bus.gb_rdata),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .done      (w_ser_done)
  );

  assign bus.in_ready = w_in_ready;
  assign bus.gb_addr  = r_addr;
  assign bus.gb_wdata = r_wdata;
  assign bus.gb_we    = w_we;
  assign bus.gb_re    = w_re;
  assign busy         = w_busy;
  assign err_cnt      = r_err;

endmodule
`default_nettype wire
